// File: rtl/ttt_board_judge.sv
// rtl/ttt_board_judge.sv - 3x3 board store, move legality check and win/draw/forfeit judge
// Optional macro TTT_WIN_LINE_EN adds the registered win_line output.

module ttt_board_judge #(
  parameter int POS_W         = 4,
  parameter int FORFEIT_LIMIT = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             play,
  input  logic             P1_play,
  input  logic             P2_play,
  input  logic [POS_W-1:0] pos,
  output logic [17:0]      board,
  output logic             win,
  output logic             no_space,
  output logic [1:0]       winner,
  output logic             illegal_move,
`ifdef TTT_WIN_LINE_EN
  output logic [2:0]       win_line,
`endif
  output logic [3:0]       move_count
);

  typedef enum logic {ST_PLAY, ST_DONE} state_t;

  localparam int SW = (FORFEIT_LIMIT < 2) ? 1 : $clog2(FORFEIT_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(FORFEIT_LIMIT);

  // Cell triples in win_line index order: rows, columns, then the two diagonals.
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };

  state_t        state;
  logic [1:0]    cells [9];
  logic [1:0]    nb    [9];
  logic [SW-1:0] strike1;
  logic [SW-1:0] strike2;

  logic          take;
  logic          pos_ok;
  logic [3:0]    cidx;
  logic          legal;
  logic          bad;
  logic [1:0]    mover;
  logic [1:0]    opponent;
  logic [SW-1:0] mover_strike;
  logic [SW-1:0] strike_nxt;
  logic          forfeit;
  logic          line_hit;
  logic [3:0]    count_nxt;
  logic          win_set;
  logic          ns_set;
`ifdef TTT_WIN_LINE_EN
  logic [2:0]    line_idx;
`endif

  always_comb begin
    take         = play && (state == ST_PLAY) && (P1_play ^ P2_play);
    mover        = P1_play ? 2'b01 : 2'b10;
    opponent     = P1_play ? 2'b10 : 2'b01;
    pos_ok       = (pos <= POS_W'(8));
    cidx         = pos_ok ? 4'(pos) : 4'd0;
    legal        = take && pos_ok && (cells[cidx] == 2'b00);
    bad          = take && !legal;
    mover_strike = P1_play ? strike1 : strike2;
    strike_nxt   = '0;
    if (bad) begin
      strike_nxt = (mover_strike == LIMIT) ? LIMIT : mover_strike + 1'b1;
    end
    forfeit      = bad && (FORFEIT_LIMIT > 0) && (strike_nxt == LIMIT);
    count_nxt    = move_count + {3'd0, legal};
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      nb[k] = (legal && (cidx == 4'(k))) ? mover : cells[k];
    end
  end

  // Only the current mover can complete a line, since any earlier line would already have ended the game.
  always_comb begin
    line_hit = 1'b0;
`ifdef TTT_WIN_LINE_EN
    line_idx = 3'd0;
`endif
    for (int l = 7; l >= 0; l--) begin
      if ((nb[LINES[l][0]] != 2'b00) &&
          (nb[LINES[l][0]] == nb[LINES[l][1]]) &&
          (nb[LINES[l][1]] == nb[LINES[l][2]])) begin
        line_hit = 1'b1;
`ifdef TTT_WIN_LINE_EN
        line_idx = 3'(l);
`endif
      end
    end
  end

  always_comb begin
    win_set = (legal && line_hit) || forfeit;
    ns_set  = legal && (count_nxt == 4'd9);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_PLAY;
      win          <= 1'b0;
      no_space     <= 1'b0;
      winner       <= 2'b00;
      illegal_move <= 1'b0;
      move_count   <= 4'd0;
      strike1      <= '0;
      strike2      <= '0;
`ifdef TTT_WIN_LINE_EN
      win_line     <= 3'd0;
`endif
      for (int k = 0; k < 9; k++) cells[k] <= 2'b00;
    end else if (clear) begin
      state        <= ST_PLAY;
      win          <= 1'b0;
      no_space     <= 1'b0;
      winner       <= 2'b00;
      illegal_move <= 1'b0;
      move_count   <= 4'd0;
      strike1      <= '0;
      strike2      <= '0;
`ifdef TTT_WIN_LINE_EN
      win_line     <= 3'd0;
`endif
      for (int k = 0; k < 9; k++) cells[k] <= 2'b00;
    end else begin
      illegal_move <= bad;
      if (legal) begin
        cells[cidx] <= mover;
        move_count  <= count_nxt;
      end
      if (take) begin
        if (P1_play) strike1 <= strike_nxt;
        else         strike2 <= strike_nxt;
      end
      if (win_set) begin
        win    <= 1'b1;
        winner <= forfeit ? opponent : mover;
`ifdef TTT_WIN_LINE_EN
        win_line <= forfeit ? 3'd0 : line_idx;
`endif
      end
      if (ns_set) no_space <= 1'b1;
      case (state)
        ST_PLAY: if (win_set || ns_set) state <= ST_DONE;
        default: state <= ST_DONE;
      endcase
    end
  end

  always_comb begin
    board = '0;
    for (int k = 0; k < 9; k++) board[2*k +: 2] = cells[k];
  end

endmodule

// File: tb/tb_ttt_board_judge.sv
// tb/tb_ttt_board_judge.sv - directed bench with per-cycle reference model for ttt_board_judge
// Exercises win_line too when TTT_WIN_LINE_EN is defined.

module tb_ttt_board_judge;

  localparam int FL = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        play = 1'b0;
  logic        P1_play = 1'b0;
  logic        P2_play = 1'b0;
  logic [3:0]  pos = 4'd0;
  logic [17:0] board;
  logic        win;
  logic        no_space;
  logic [1:0]  winner;
  logic        illegal_move;
  logic [3:0]  move_count;
`ifdef TTT_WIN_LINE_EN
  logic [2:0]  win_line;
`endif

  int tests = 0;
  int fails = 0;

  ttt_board_judge #(.POS_W(4), .FORFEIT_LIMIT(FL)) dut (
    .clock(clock), .reset(reset), .clear(clear), .play(play),
    .P1_play(P1_play), .P2_play(P2_play), .pos(pos),
    .board(board), .win(win), .no_space(no_space), .winner(winner),
    .illegal_move(illegal_move),
`ifdef TTT_WIN_LINE_EN
    .win_line(win_line),
`endif
    .move_count(move_count)
  );

  always #5 clock = ~clock;

  // Reference model: plain game rules over an integer board.
  int m_cell [9];
  int m_strike [3];
  int m_count = 0;
  int m_winner = 0;
  bit m_win = 0;
  bit m_ns = 0;
  bit m_ill = 0;
  bit m_done = 0;
`ifdef TTT_WIN_LINE_EN
  int m_wl = 0;
`endif
  logic [17:0] exp_board;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 9; k++) m_cell[k] = 0;
    for (int k = 0; k < 3; k++) m_strike[k] = 0;
    m_count = 0; m_winner = 0; m_win = 0; m_ns = 0; m_ill = 0; m_done = 0;
`ifdef TTT_WIN_LINE_EN
    m_wl = 0;
`endif
  endtask

  function automatic int m_line();
    for (int r = 0; r < 3; r++)
      if (m_cell[3*r] != 0 && m_cell[3*r] == m_cell[3*r+1] && m_cell[3*r] == m_cell[3*r+2]) return r;
    for (int c = 0; c < 3; c++)
      if (m_cell[c] != 0 && m_cell[c] == m_cell[c+3] && m_cell[c] == m_cell[c+6]) return 3 + c;
    if (m_cell[4] != 0 && m_cell[0] == m_cell[4] && m_cell[8] == m_cell[4]) return 6;
    if (m_cell[4] != 0 && m_cell[2] == m_cell[4] && m_cell[6] == m_cell[4]) return 7;
    return -1;
  endfunction

  always @(posedge clock or negedge reset) begin : model
    int p;
    int l;
    if (!reset || clear) begin
      m_clear();
    end else begin
      m_ill = 0;
      if (play && !m_done && (P1_play != P2_play)) begin
        p = P1_play ? 1 : 2;
        if (pos <= 8 && m_cell[pos] == 0) begin
          m_cell[pos] = p;
          m_count++;
          m_strike[p] = 0;
          l = m_line();
          if (l >= 0) begin
            m_win = 1; m_winner = p;
`ifdef TTT_WIN_LINE_EN
            m_wl = l;
`endif
          end
          if (m_count == 9) m_ns = 1;
        end else begin
          m_ill = 1;
          if (m_strike[p] < FL) m_strike[p]++;
          if (FL > 0 && m_strike[p] == FL) begin
            m_win = 1; m_winner = 3 - p;
`ifdef TTT_WIN_LINE_EN
            m_wl = 0;
`endif
          end
        end
        m_done = m_win || m_ns;
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 9; k++) exp_board[2*k +: 2] = 2'(m_cell[k]);
    chk("board", 32'(board), 32'(exp_board));
    chk("win", 32'(win), 32'(m_win));
    chk("no_space", 32'(no_space), 32'(m_ns));
    chk("winner", 32'(winner), 32'(m_winner));
    chk("illegal_move", 32'(illegal_move), 32'(m_ill));
    chk("move_count", 32'(move_count), 32'(m_count));
`ifdef TTT_WIN_LINE_EN
    chk("win_line", 32'(win_line), 32'(m_wl));
`endif
  end

  // Called at a falling edge; returns one falling edge later with the result visible.
  task automatic mv(input int p, input int ps);
    play = 1'b1;
    P1_play = (p == 1) || (p == 3);
    P2_play = (p == 2) || (p == 3);
    pos = 4'(ps);
    @(negedge clock);
    play = 1'b0; P1_play = 1'b0; P2_play = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
  int full_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 8, 6};

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("idle board", 32'(board), 32'h0);
    chk("idle win", 32'(win), 32'h0);
    chk("idle move_count", 32'(move_count), 32'h0);

    mv(0, 0);
    mv(3, 1);
    chk("start pulse ignored", 32'(board), 32'h0);

    mv(1, 0); mv(2, 3); mv(1, 1); mv(2, 4); mv(1, 2);
    chk("row win", 32'(win), 32'h1);
    chk("row winner", 32'(winner), 32'h1);
    chk("row board low", 32'(board[5:0]), 32'h15);
    chk("row board", 32'(board), 32'h295);
    chk("row count", 32'(move_count), 32'h5);
`ifdef TTT_WIN_LINE_EN
    chk("row win_line", 32'(win_line), 32'h0);
`endif
    mv(2, 8);
    chk("done ignores play", 32'(board), 32'h295);

    clr();
    chk("clear board", 32'(board), 32'h0);
    mv(1, 4); mv(2, 4);
    chk("occupied illegal", 32'(illegal_move), 32'h1);
    chk("occupied cell", 32'(board[9:8]), 32'h1);
    chk("occupied count", 32'(move_count), 32'h1);
    @(negedge clock);
    chk("illegal one cycle", 32'(illegal_move), 32'h0);
    mv(2, 15);
    chk("pos 15 illegal", 32'(illegal_move), 32'h1);

    clr();
    for (int i = 0; i < 9; i++) mv((i % 2) + 1, draw_seq[i]);
    chk("draw no_space", 32'(no_space), 32'h1);
    chk("draw win", 32'(win), 32'h0);
    chk("draw winner", 32'(winner), 32'h0);
    chk("draw count", 32'(move_count), 32'h9);
    chk("draw board", 32'(board), 32'h16A59);

    clr();
    for (int i = 0; i < 9; i++) mv((i % 2) + 1, full_seq[i]);
    chk("ninth win", 32'(win), 32'h1);
    chk("ninth no_space", 32'(no_space), 32'h1);
    chk("ninth winner", 32'(winner), 32'h1);
`ifdef TTT_WIN_LINE_EN
    chk("ninth win_line", 32'(win_line), 32'h3);
`endif

    clr();
    mv(2, 9); mv(1, 0); mv(2, 9); mv(1, 1);
    chk("two strikes no win", 32'(win), 32'h0);
    mv(2, 9);
    chk("forfeit win", 32'(win), 32'h1);
    chk("forfeit winner", 32'(winner), 32'h1);
    chk("forfeit board", 32'(board), 32'h5);

    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async reset board", 32'(board), 32'h0);
    chk("async reset win", 32'(win), 32'h0);
    chk("async reset winner", 32'(winner), 32'h0);
    chk("async reset count", 32'(move_count), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    mv(1, 4);
    clear = 1'b1; play = 1'b1; P2_play = 1'b1; pos = 4'd0;
    @(negedge clock);
    clear = 1'b0; play = 1'b0; P2_play = 1'b0;
    chk("clear+play board", 32'(board), 32'h0);
    chk("clear+play count", 32'(move_count), 32'h0);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ttt_board_judge.md
Name: ttt_board_judge

Overview:
- Board-side responder to the game FSM controller.
- Consumes the controller's `play`, `P1_play` and `P2_play`, stores the 3x3 board, and checks each placement for legality.
- Produces the `win` and `no_space` status that the controller samples to pick its next state.
- Sits between the player move inputs and the controller; one instance per game.

Parameters:
- POS_W, 4, width of the cell index `pos`; legal values are 0..8, row-major with cell 0 at top-left.
- FORFEIT_LIMIT, 3, consecutive illegal moves by one player that forfeit the game to the opponent; 0 disables forfeit.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- clear  input  1  synchronous new-game request; clears the board, counters and outputs.
- play  input  1  move strobe, one cycle per move (same signal the controller sees).
- P1_play  input  1  controller grants the turn to player 1.
- P2_play  input  1  controller grants the turn to player 2.
- pos  input  POS_W  cell index of the move, sampled when `play` is high.
- board  output  18  cell k occupies bits [2k+1:2k]; 00 = empty, 01 = P1, 10 = P2.
- win  output  1  a player has won (by a line or by forfeit).
- no_space  output  1  all 9 cells are occupied.
- winner  output  2  01 = P1, 10 = P2, 00 = none.
- illegal_move  output  1  one-cycle pulse when a move is rejected.
- move_count  output  4  number of legal moves placed, 0..9.

Behaviour:
- Reset values (reset low): board = 0, win = 0, no_space = 0, winner = 00, illegal_move = 0, move_count = 0, both strike counters = 0, state = PLAY.
- State machine with two states:
  - PLAY -> DONE when the registered update sets `win` or `no_space`.
  - DONE -> PLAY only on `clear` or `reset`.
- Move acceptance: a move is taken when `play` = 1, state = PLAY, and exactly one of `P1_play`/`P2_play` is high.
  - Any other `play` pulse is ignored with no side effects: both grants low (controller IDLE/GAME_DONE), both high, or state = DONE.
  - This ignore rule covers the controller's IDLE-to-PLAYER1 start pulse, which must not place a piece.
- Legal move: `pos` <= 8 and the target cell is 00.
  - The player code is written into the cell.
  - `move_count` increments.
  - The moving player's strike counter is cleared.
- Illegal move: `pos` > 8 or the target cell is occupied.
  - Board and `move_count` are unchanged.
  - `illegal_move` = 1 for exactly one cycle.
  - The moving player's strike counter increments, saturating at FORFEIT_LIMIT.
- Latency:
  - Win evaluation runs combinationally on the next-board value and is registered on the same edge as the board write.
  - `win`, `winner` and `no_space` are valid in the cycle after the `play` pulse, before the controller's next `play`.
- Win lines (8): rows {0,1,2}, {3,4,5}, {6,7,8}; columns {0,3,6}, {1,4,7}, {2,5,8}; diagonals {0,4,8}, {2,4,6}.
  - A line wins when all three cells are equal and nonzero.
  - `winner` takes the mover's code.
- Forfeit: when the strike counter reaches FORFEIT_LIMIT (FORFEIT_LIMIT > 0), `win` = 1 and `winner` = the opponent's code.
- `no_space` = (`move_count` == 9).
- A 9th move that completes a line sets `win` = 1 and `no_space` = 1 together, with `winner` = mover.
- `win`, `winner` and `no_space` are sticky until `clear` or `reset`.
- Priority order: `reset` > `clear` > `play`.
  - `clear` together with `play` clears the state and discards the move.
- Reset mid-game: all outputs return to reset values asynchronously; there is no pending-move carry-over.

Optional Feature:
- Macro: TTT_WIN_LINE_EN.
- When defined:
  - Adds output `win_line` [2:0], registered with `win`.
  - Encoding: index of the completing line, in order rows 0-2 = 0..2, columns 0-2 = 3..5, diagonal {0,4,8} = 6, diagonal {2,4,6} = 7.
  - If a single move completes two lines, the lowest index is reported.
  - Forfeit reports 0; reset value is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Release reset, then idle 5 cycles -> board = 0, win = 0, no_space = 0, winner = 00, move_count = 0, illegal_move never pulses.
- Play alternating P1/P2 at positions 0, 3, 1, 4, 2 -> after the 5th pulse: win = 1, winner = 01, board[5:0] = 010101, move_count = 5.
  - A further P2 play at pos 8 is ignored; board is unchanged.
- P1 plays pos 4, then P2 plays pos 4 -> second move pulses illegal_move for 1 cycle; board[9:8] = 01, move_count = 1.
- Draw sequence P1 0, P2 1, P1 2, P2 4, P1 3, P2 5, P1 7, P2 6, P1 8 -> no_space = 1, win = 0, winner = 00, move_count = 9.
- With FORFEIT_LIMIT = 3, three P2 moves with pos = 9 (interleaved with legal P1 moves at 0, 1) -> after the third: win = 1, winner = 01.
- Mid-game, drive reset low between clock edges -> outputs are 0 before the next edge.
  - Separately, `clear` and `play` high in the same cycle -> board = 0 and move_count = 0 on the next cycle; the move is not placed.
